// File: rtl/rnw1_port_ram_pkg.sv
// rnw1_port_ram_pkg: FSM state encoding and port-slice helper for rnw1_port_ram.
package rnw1_port_ram_pkg;

    typedef enum logic {CLEAR, READY} state_e;

    function automatic int slice_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/rw_port_ram.sv
// rw_port_ram: single-read / single-write RAM, registered read, read-first on collision.
module rw_port_ram #(
    parameter int    DATA_WIDTH = 8,
    parameter int    ADDR_WIDTH = 12,
    parameter string RAM_TYPE   = "auto"
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_w_i,
    input  logic [DATA_WIDTH-1:0] data_w_i,
    input  logic [ADDR_WIDTH-1:0] addr_r_i,
    output logic [DATA_WIDTH-1:0] data_r_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_w_i] <= data_w_i;
        data_r_o <= mem_q[addr_r_i];
    end

endmodule

// File: rtl/rnw1_port_ram.sv
// rnw1_port_ram: N-read/1-write RAM built from lock-step replicas, with post-reset clear sequencer.
// Define RNW1_PORT_RAM_BYPASS_EN for write-first collisions; default is read-first.
module rnw1_port_ram
    import rnw1_port_ram_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    ADDR_WIDTH  = 12,
    parameter int                    READ_PORTS  = 2,
    parameter string                 RAM_TYPE    = "auto",
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0] addr_r,
    input  logic [ADDR_WIDTH-1:0]            addr_w,
    input  logic [DATA_WIDTH-1:0]            data_in,
    input  logic                             we,
    output logic [READ_PORTS*DATA_WIDTH-1:0] data_out,
    output logic                             busy
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  clr, wen;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;

    // The sequencer owns the shared write port until the last word is cleared.
    always_comb begin
        clr     = state_q == CLEAR;
        cnt_d   = clr ? cnt_q + 1'b1 : cnt_q;
        state_d = (clr && cnt_q == '1) ? READY : state_q;
        wen     = clr | we;
        waddr   = clr ? cnt_q : addr_w;
        wdata   = clr ? CLEAR_VALUE : data_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = clr;

    for (genvar i = 0; i < READ_PORTS; i++) begin : g_port
        localparam int AL = slice_lo(i, ADDR_WIDTH);
        localparam int DL = slice_lo(i, DATA_WIDTH);
        logic [DATA_WIDTH-1:0] ram_q, rd;

        rw_port_ram #(
            .DATA_WIDTH(DATA_WIDTH),
            .ADDR_WIDTH(ADDR_WIDTH),
            .RAM_TYPE  (RAM_TYPE)
        ) u_ram (
            .clk     (clk),
            .we_i    (wen),
            .addr_w_i(waddr),
            .data_w_i(wdata),
            .addr_r_i(addr_r[AL +: ADDR_WIDTH]),
            .data_r_o(ram_q)
        );

`ifdef RNW1_PORT_RAM_BYPASS_EN
        logic                  hit_q;
        logic [DATA_WIDTH-1:0] wd_q;

        always_ff @(posedge clk) begin
            if (reset) hit_q <= 1'b0;
            else       hit_q <= !clr && we && addr_r[AL +: ADDR_WIDTH] == addr_w;
        end

        always_ff @(posedge clk) wd_q <= data_in;

        assign rd = hit_q ? wd_q : ram_q;
`else
        assign rd = ram_q;
`endif

        assign data_out[DL +: DATA_WIDTH] = clr ? CLEAR_VALUE : rd;
    end

endmodule
